// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Two-requester Wishbone arbiter with a round-robin grant and a
//            stb-without-ack watchdog. It grants one requester per bus cycle
//            (cyc high) and holds that grant until the requester drops cyc.
//            A single dead cycle separates consecutive grants.
// Ports    : clk_i, rst_i (async, active-low)
//            m0_*/m1_* : requester cyc/stb/we/adr/dat inputs, dat/ack/err outs
//            s_*       : shared slave port
//            gnt_o     : one-hot current grant (00 when idle)
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_OWNED   = 2'd1;
    localparam logic [1:0] c_ERR     = 2'd2;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [1:0] r_gnt;
    logic       r_last;     // 1: requester 1 was granted last
    logic [7:0] r_cnt;
    logic [1:0] r_err;

    logic w_owned;
    logic w_any;
    logic w_pick1;
    logic w_sel_cyc;
    logic w_sel_stb;
    logic w_stall;
    logic w_timeout;

    assign w_owned   = (r_state == c_OWNED);
    assign w_any     = m0_cyc_i | m1_cyc_i;
    // Requester 1 wins if alone, or if both request and requester 0 went last.
    assign w_pick1   = m1_cyc_i & (~m0_cyc_i | ~r_last);
    assign w_sel_cyc = r_gnt[1] ? m1_cyc_i : m0_cyc_i;
    assign w_sel_stb = r_gnt[1] ? m1_stb_i : m0_stb_i;
    // An unacked strobe cycle; an ack in the same cycle always wins.
    assign w_stall   = w_owned & w_sel_cyc & w_sel_stb & ~s_ack_i;
    assign w_timeout = w_stall & ((r_cnt + 8'd1) == c_TIMEOUT);

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_next_state = c_OWNED;
                end
            end
            c_OWNED: begin
                if (!w_sel_cyc) begin
                    w_next_state = c_IDLE;
                end else if (w_timeout) begin
                    w_next_state = c_ERR;
                end
            end
            c_ERR: begin
                if (!w_sel_cyc) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Grant, priority pointer, watchdog and error pulse
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_gnt  <= 2'b00;
            r_last <= 1'b1;
            r_cnt  <= 8'd0;
            r_err  <= 2'b00;
        end else begin
            r_err <= w_timeout ? r_gnt : 2'b00;

            if (r_state == c_IDLE && w_any) begin
                r_gnt  <= w_pick1 ? 2'b10 : 2'b01;
                r_last <= w_pick1;
            end else if (w_next_state == c_IDLE) begin
                r_gnt <= 2'b00;
            end

            if (w_stall && !w_timeout) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    // Output logic
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        if (w_owned) begin
            s_cyc_o  = w_sel_cyc;
            s_stb_o  = w_sel_stb;
            s_we_o   = r_gnt[1] ? m1_we_i  : m0_we_i;
            s_adr_o  = r_gnt[1] ? m1_adr_i : m0_adr_i;
            s_dat_o  = r_gnt[1] ? m1_dat_i : m0_dat_i;
            m0_ack_o = r_gnt[0] & s_ack_i;
            m1_ack_o = r_gnt[1] & s_ack_i;
        end
        if (r_gnt[0]) begin
            m0_dat_o = s_dat_i;
        end
        if (r_gnt[1]) begin
            m1_dat_o = s_dat_i;
        end
    end

    assign m0_err_o = r_err[0];
    assign m1_err_o = r_err[1];
    assign gnt_o    = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_rr_arbiter
// Purpose  : Directed self-checking bench for wb_rr_arbiter (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
    logic [1:0] m0_adr_i = '0;
    logic [7:0] m0_dat_i = '0;
    logic [7:0] m0_dat_o;
    logic       m0_ack_o, m0_err_o;
    logic       m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
    logic [1:0] m1_adr_i = '0;
    logic [7:0] m1_dat_i = '0;
    logic [7:0] m1_dat_o;
    logic       m1_ack_o, m1_err_o;
    logic       s_cyc_o, s_stb_o, s_we_o;
    logic [1:0] s_adr_o;
    logic [7:0] s_dat_o;
    logic [7:0] s_dat_i = '0;
    logic       s_ack_i = 1'b0;
    logic [1:0] gnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_rr_arbiter #(
        .ADDR_WIDTH (2),
        .DATA_WIDTH (8),
        .TIMEOUT    (4)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .gnt_o    (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #3;
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_scyc", s_cyc_o, 1'b0);
        check("rst_ack", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
        #9;
        rst_i = 1'b1;  // released at t=12, before the edge at t=15

        // ---------------- simultaneous request from reset ----------------
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 2'd2; m0_dat_i = 8'h11;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 2'd3; m1_dat_i = 8'h22;
        #1;
        check("sim_idle_scyc", s_cyc_o, 1'b0);
        step();
        check("sim_first_gnt", gnt_o, 2'b01);
        check("sim_first_adr", s_adr_o, 2'd2);
        s_ack_i = 1; s_dat_i = 8'h5A;
        #1;
        check("sim_m0_ack", {m0_ack_o, m1_ack_o}, 2'b10);
        check("sim_m0_dat", m0_dat_o, 8'h5A);
        check("sim_m1_dat", m1_dat_o, 8'h00);
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        check("sim_drop_scyc", s_cyc_o, 1'b0);
        step();
        check("sim_dead_gnt", gnt_o, 2'b00);
        check("sim_dead_scyc", s_cyc_o, 1'b0);
        step();
        check("sim_second_gnt", gnt_o, 2'b10);
        check("sim_second_adr", s_adr_o, 2'd3);
        check("sim_second_dat", s_dat_o, 8'h22);
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        check("sim_end_gnt", gnt_o, 2'b00);

        // ---------------- single write request ----------------
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 2'b01; m0_dat_i = 8'hA5;
        #1;
        check("wr_pre_scyc", s_cyc_o, 1'b0);
        step();
        check("wr_gnt", gnt_o, 2'b01);
        check("wr_bus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}, {3'b111, 2'b01, 8'hA5});
        step();
        step();
        s_ack_i = 1;
        #1;
        check("wr_ack", {m0_ack_o, m1_ack_o}, 2'b10);
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        #1;
        check("wr_ack_low", m0_ack_o, 1'b0);
        check("wr_no_err", m0_err_o, 1'b0);
        step();
        check("wr_idle_gnt", gnt_o, 2'b00);

        // ---------------- fairness: both requesting continuously ----------------
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("rr_gnt%0d", i), gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            s_ack_i = 1;
            #1;
            check($sformatf("rr_ack%0d", i), {m1_ack_o, m0_ack_o}, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
            s_ack_i = 0;
            if (i % 2 == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
            else            begin m1_cyc_i = 0; m1_stb_i = 0; end
            step();
            check($sformatf("rr_dead%0d", i), gnt_o, 2'b00);
            m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        end
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();

        // ---------------- held grant: m1 read then write, m0 waiting ----------------
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 2'd1;
        step();
        check("held_gnt", gnt_o, 2'b10);
        m0_cyc_i = 1; m0_stb_i = 1;
        s_dat_i = 8'h3C; s_ack_i = 1;
        #1;
        check("held_rd_dat", m1_dat_o, 8'h3C);
        check("held_rd_ack", {m0_ack_o, m1_ack_o}, 2'b01);
        check("held_m0_dat", m0_dat_o, 8'h00);
        step();
        m1_we_i = 1; m1_dat_i = 8'h77;
        #1;
        check("held_wr_bus", {s_we_o, s_dat_o, gnt_o}, {1'b1, 8'h77, 2'b10});
        check("held_wr_ack", {m0_ack_o, m1_ack_o}, 2'b01);
        step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        step();
        check("held_dead", gnt_o, 2'b00);
        step();
        check("held_m0_gnt", gnt_o, 2'b01);
        check("held_m0_noerr", m0_err_o, 1'b0);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();

        // ---------------- timeout ----------------
        m0_cyc_i = 1; m0_stb_i = 1;
        step();                      // granted
        check("to_gnt", gnt_o, 2'b01);
        step(); step(); step();      // three unacked cycles
        check("to_pre_stb", s_stb_o, 1'b1);
        check("to_pre_err", m0_err_o, 1'b0);
        step();                      // fourth unacked cycle ends
        check("to_err", {m0_err_o, m1_err_o}, 2'b10);
        check("to_bus_off", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        check("to_gnt_held", gnt_o, 2'b01);
        s_ack_i = 1;
        #1;
        check("to_ack_ignored", m0_ack_o, 1'b0);
        step();
        s_ack_i = 0;
        check("to_err_pulse", m0_err_o, 1'b0);
        check("to_err_gnt", gnt_o, 2'b01);
        m0_cyc_i = 0; m0_stb_i = 0;
        step();
        check("to_idle", gnt_o, 2'b00);

        // ack on the fourth cycle wins
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        step(); step(); step();
        s_ack_i = 1;
        #1;
        check("tob_ack", m0_ack_o, 1'b1);
        step();
        s_ack_i = 0;
        check("tob_no_err", m0_err_o, 1'b0);
        check("tob_owned", {s_cyc_o, gnt_o}, {1'b1, 2'b01});
        m0_cyc_i = 0; m0_stb_i = 0;
        step();

        // ---------------- reset mid-transfer ----------------
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        s_ack_i = 1;
        #1;
        check("mrst_pre_ack", m1_ack_o, 1'b1);
        rst_i = 0;
        #1;
        check("mrst_bus", {s_cyc_o, gnt_o, m1_ack_o}, 4'b0000);
        s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
        #1;
        rst_i = 1;
        step();
        check("mrst_gnt_m0", gnt_o, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum stb-without-ack cycles, range 1..255.
REQ-004 SHALL have one clock and one reset: clk_i  in  1  rising-edge clock; rst_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have, per requester n in {0,1}: mn_cyc_i  in  1  cycle; mn_stb_i  in  1  strobe; mn_we_i  in  1  write enable; mn_adr_i  in  ADDR_WIDTH  address; mn_dat_i  in  DATA_WIDTH  write data.
REQ-006 SHALL have, per requester n: mn_dat_o  out  DATA_WIDTH  read data; mn_ack_o  out  1  acknowledge; mn_err_o  out  1  timeout error pulse.
REQ-007 SHALL have shared-port signals: s_cyc_o  out  1; s_stb_o  out  1; s_we_o  out  1; s_adr_o  out  ADDR_WIDTH; s_dat_o  out  DATA_WIDTH; s_dat_i  in  DATA_WIDTH; s_ack_i  in  1.
REQ-008 SHALL have gnt_o  out  2  one-hot current grant, 2'b00 when idle.

Function
REQ-009 SHALL implement FSM states IDLE, OWNED, ERR.
REQ-010 IDLE: gnt_o=00, all s_* outputs 0; on a clock edge with any mn_cyc_i=1, register the grant and enter OWNED.
REQ-011 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; with one requesting, grant it; priority pointer updates only on grant.
REQ-012 Grant latency SHALL be exactly one cycle: mn_cyc_i sampled at edge k -> s_cyc_o/gnt_o high after edge k.
REQ-013 OWNED: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o SHALL combinationally follow the granted requester's inputs.
REQ-014 OWNED: s_ack_i SHALL route combinationally to the granted mn_ack_o only; the non-granted mn_ack_o SHALL be 0.
REQ-015 mn_dat_o SHALL equal s_dat_i for the granted requester, 0 otherwise.
REQ-016 Grant SHALL be held across multiple stb/ack transfers while the granted mn_cyc_i stays 1; a non-granted requester SHALL wait without timeout.
REQ-017 On an edge where the granted mn_cyc_i=0, SHALL return to IDLE; one dead cycle (s_cyc_o=0) always separates consecutive grants.
REQ-018 An 8-bit watchdog counter SHALL increment each cycle in OWNED with s_stb_o=1 and s_ack_i=0, and clear on s_ack_i=1, on s_stb_o=0, or on leaving OWNED.
REQ-019 When the counter reaches TIMEOUT, SHALL pulse the granted mn_err_o for exactly one cycle and enter ERR.
REQ-020 ERR: s_cyc_o=s_stb_o=s_we_o=0, no ack routed, gnt_o held; on the granted mn_cyc_i=0, enter IDLE.
REQ-021 s_ack_i arriving on the same edge the counter would reach TIMEOUT SHALL win: transfer completes, no error.
REQ-022 s_ack_i while in IDLE or ERR SHALL be ignored.

Reset
REQ-023 rst_i=0 SHALL immediately force state IDLE, gnt_o=00, counter 0, priority pointer favouring requester 0, all outputs 0, regardless of an in-flight transfer.
REQ-024 After rst_i deasserts, arbitration SHALL begin on the first rising clk_i edge.

Verification
REQ-025 Single request: m0 writes adr=2'b01, dat=8'hA5, slave acks after 3 cycles -> s_cyc_o high 1 cycle after m0_cyc_i, s_adr_o=01, s_dat_o=A5, m0_ack_o=1 one cycle, gnt_o=01.
REQ-026 Simultaneous request from reset: m0 and m1 raise cyc same edge -> m0 granted first; after m0 drops cyc, one dead cycle, m1 granted (gnt_o=10).
REQ-027 Fairness: both requesters issue continuous back-to-back cycles for 6 grants -> grant order 0,1,0,1,0,1.
REQ-028 Held grant: m1 performs read (s_dat_i=8'h3C) then write without dropping cyc while m0 requests -> m1 receives m1_dat_o=3C with ack, m0 waits, m0_ack_o stays 0.
REQ-029 Timeout: TIMEOUT=4, slave never acks -> m0_err_o pulses one cycle after 4th unacked stb cycle, s_stb_o drops same cycle, IDLE once m0_cyc_i=0; ack on 4th cycle -> no error.
REQ-030 Reset mid-transfer: rst_i=0 while m1 owns bus with stb high -> s_cyc_o, gnt_o, m1_ack_o go 0 without waiting for clk_i; after release, simultaneous requests grant m0 first.
